// File: rtl/sync_realign.sv
// sync_realign: re-aligns source video timing {vs,hs,de} with the output of a
// processing pipeline whose latency is fixed but unknown at design time.
//
// Once per frame (after a vsync rising edge) the block counts the cycles from
// the first i_de rising edge to the first i_valid rising edge. That count
// becomes the delay applied to the timing signals through a small ring buffer,
// so the registered outputs line up with the registered pixel data.
//
// Optional feature macro: SYNC_REALIGN_RECOVER_EN
//   defined     : a mismatch while locked drops lock and remeasures next frame
//   not defined : a mismatch while locked only raises the sticky error flag
module sync_realign #(
  parameter int DATA_WIDTH = 12,
  parameter int MAX_DLY    = 64,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_vs,
  input  logic                  i_hs,
  input  logic                  i_de,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_vs,
  output logic                  o_hs,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_locked,
  output logic [ADDR_W-1:0]     o_latency,
  output logic                  o_err
);

  // Largest elapsed count before a measurement is abandoned.
  localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(MAX_DLY - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_DE = 2'd1,
    ST_COUNT   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [2:0]            r_ring [MAX_DLY];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_cnt;
  logic [ADDR_W-1:0]     r_lat;
  logic                  r_vs_d;
  logic                  r_de_d;
  logic                  r_valid_d;
  logic                  r_locked;
  logic                  r_err;
  logic [2:0]            r_sync;
  logic [DATA_WIDTH-1:0] r_data;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [2:0]        w_sync_in;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [2:0]        w_ring_rd;
  logic [2:0]        w_buf;
  logic [ADDR_W-1:0] w_cnt_inc;
  logic              w_vs_rise;
  logic              w_de_rise;
  logic              w_valid_rise;
  logic              w_mismatch;

  assign w_sync_in    = {i_vs, i_hs, i_de};
  assign w_vs_rise    = i_vs & ~r_vs_d;
  assign w_de_rise    = i_de & ~r_de_d;
  assign w_valid_rise = i_valid & ~r_valid_d;

  // Entry written lat cycles ago; subtraction wraps naturally modulo MAX_DLY.
  assign w_rd_addr = r_wr_ptr - r_lat;
  assign w_ring_rd = r_ring[w_rd_addr];

  // r_cnt is cleared on the i_de rising edge, so in the k-th cycle after that
  // edge r_cnt holds k-1; the incremented value is the elapsed cycle count.
  assign w_cnt_inc = r_cnt + ADDR_W'(1);

  // The delayed data-enable must track pipeline valid while locked.
  assign w_mismatch = i_valid ^ w_buf[0];

  // Select the delayed timing word; a zero delay bypasses the ring entirely.
  always_comb begin
    w_buf = 3'b000;
    if (r_lat == {ADDR_W{1'b0}}) begin
      w_buf = w_sync_in;
    end else begin
      w_buf = w_ring_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Ring buffer: captures the undelayed timing word every cycle in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_DLY; i++) begin
        r_ring[i] <= 3'b000;
      end
    end else begin
      r_ring[r_wr_ptr] <= w_sync_in;
    end
  end

  // Write pointer advances every cycle and wraps at MAX_DLY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {ADDR_W{1'b0}};
    end else begin
      r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
    end
  end

  // One-cycle history of vs/de/valid for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d    <= 1'b0;
      r_de_d    <= 1'b0;
      r_valid_d <= 1'b0;
    end else begin
      r_vs_d    <= i_vs;
      r_de_d    <= i_de;
      r_valid_d <= i_valid;
    end
  end

  // Measurement / lock FSM with registered lock, latency and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {ADDR_W{1'b0}};
      r_lat    <= {ADDR_W{1'b0}};
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_locked <= 1'b0;
          if (w_vs_rise) begin
            r_state <= ST_WAIT_DE;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_WAIT_DE: begin
          // Further vsync edges are ignored once a frame has started.
          if (w_de_rise) begin
            r_cnt <= {ADDR_W{1'b0}};
            if (w_valid_rise) begin
              // Pipeline is combinationally transparent: zero delay.
              r_lat    <= {ADDR_W{1'b0}};
              r_locked <= 1'b1;
              r_state  <= ST_LOCKED;
            end else begin
              r_state  <= ST_COUNT;
            end
          end else begin
            r_state <= ST_WAIT_DE;
          end
        end

        ST_COUNT: begin
          // Valid is checked first so the deepest latency (MAX_DLY-1) locks.
          if (w_valid_rise) begin
            r_lat    <= w_cnt_inc;
            r_locked <= 1'b1;
            r_state  <= ST_LOCKED;
          end else if (w_cnt_inc == CNT_MAX) begin
            r_err   <= 1'b1;
            r_cnt   <= {ADDR_W{1'b0}};
            r_state <= ST_IDLE;
          end else begin
            r_cnt   <= w_cnt_inc;
            r_state <= ST_COUNT;
          end
        end

        ST_LOCKED: begin
          if (w_mismatch) begin
            r_err <= 1'b1;
`ifdef SYNC_REALIGN_RECOVER_EN
            r_locked <= 1'b0;
            r_state  <= ST_IDLE;
`else
            r_locked <= 1'b1;
            r_state  <= ST_LOCKED;
`endif
          end else begin
            r_locked <= 1'b1;
            r_state  <= ST_LOCKED;
          end
        end

        default: begin
          r_locked <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Output registers: pixel always passes through; syncs only while locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 3'b000;
      r_data <= {DATA_WIDTH{1'b0}};
    end else begin
      r_data <= i_data;
      if (r_state == ST_LOCKED) begin
        r_sync <= w_buf;
      end else begin
        r_sync <= 3'b000;
      end
    end
  end

  assign o_vs      = r_sync[2];
  assign o_hs      = r_sync[1];
  assign o_de      = r_sync[0];
  assign o_data    = r_data;
  assign o_locked  = r_locked;
  assign o_latency = r_lat;
  assign o_err     = r_err;

endmodule
